// File: rtl/trig_lut_interp_pkg.sv
// Shared types and elaboration-time helpers for the quarter-wave trig generator.
package trig_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  typedef struct packed {
    logic swap;
    logic neg_cos;
    logic neg_sin;
  } quad_map_t;

  localparam real HALF_PI = 1.5707963267948966;

  function automatic int calc_n(input int addr_w);
    return (32'sd1 << addr_w) + 32'sd1;
  endfunction

  function automatic int calc_fb(input int angle_w, input int addr_w);
    return angle_w - 32'sd2 - addr_w;
  endfunction

  // Quadrant folding: which of the two table reads feeds cos, and which results are negated.
  function automatic quad_map_t quad_map(input quadrant_e q);
    quad_map_t m;
    case (q)
      Q0:      m = '{swap: 1'b0, neg_cos: 1'b0, neg_sin: 1'b0};
      Q1:      m = '{swap: 1'b1, neg_cos: 1'b1, neg_sin: 1'b0};
      Q2:      m = '{swap: 1'b0, neg_cos: 1'b1, neg_sin: 1'b1};
      Q3:      m = '{swap: 1'b1, neg_cos: 1'b0, neg_sin: 1'b1};
      default: m = '{swap: 1'b0, neg_cos: 1'b0, neg_sin: 1'b0};
    endcase
    return m;
  endfunction

  // round(sin(k*(pi/2)/2^addr_w) * 2^frac_w); Taylor series keeps this a plain constant function.
  function automatic int q_value(input int k, input int addr_w, input int frac_w);
    real x;
    real term;
    real sum;
    x    = real'(k) * HALF_PI / (2.0 ** addr_w);
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
      sum  = sum + term;
    end
    return $rtoi(sum * (2.0 ** frac_w) + 0.5);
  endfunction

endpackage

// File: rtl/trig_lut_interp_if.sv
// Angle-in / cosine-sine-out valid/ready stream bundle for trig_lut_interp.
interface trig_lut_interp_if #(
  parameter int ANGLE_W = 16,
  parameter int OUT_W   = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ANGLE_W-1:0]      angle;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] cosine;
  logic signed [OUT_W-1:0] sine;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, cosine, sine
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, cosine, sine
  );
endinterface

// File: rtl/trig_quarter_rom.sv
// Quarter-period sine table with registered reads; TRIG_INTERP_EN adds two more read ports.
module trig_quarter_rom
  import trig_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [ADDR_W:0] addr_a,
  input  logic [ADDR_W:0] addr_b,
`ifdef TRIG_INTERP_EN
  input  logic [ADDR_W:0] addr_c,
  input  logic [ADDR_W:0] addr_d,
  output logic [FRAC_W:0] data_c,
  output logic [FRAC_W:0] data_d,
`endif
  output logic [FRAC_W:0] data_a,
  output logic [FRAC_W:0] data_b
);
  localparam int N = calc_n(ADDR_W);

  logic [FRAC_W:0] rom_s [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int QV = q_value(k, ADDR_W, FRAC_W);
    assign rom_s[k] = (FRAC_W + 1)'(QV);
  end

  // Registered table reads, held while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a <= {(FRAC_W + 1){1'b0}};
      data_b <= {(FRAC_W + 1){1'b0}};
`ifdef TRIG_INTERP_EN
      data_c <= {(FRAC_W + 1){1'b0}};
      data_d <= {(FRAC_W + 1){1'b0}};
`endif
    end else if (en) begin
      data_a <= rom_s[addr_a];
      data_b <= rom_s[addr_b];
`ifdef TRIG_INTERP_EN
      data_c <= rom_s[addr_c];
      data_d <= rom_s[addr_d];
`endif
    end
  end

endmodule

// File: rtl/trig_lut_interp.sv
// Three-stage quarter-wave sine/cosine generator with a global stall enable.
// Define TRIG_INTERP_EN for linear interpolation between table points.
module trig_lut_interp
  import trig_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 32,
  parameter int FRAC_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  trig_lut_interp_if.slave bus
);
  localparam int FB  = calc_fb(ANGLE_W, ADDR_W);
  localparam int FBW = (FB > 0) ? FB : 1;
  localparam int TW  = FRAC_W + 1;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  if (ADDR_W < 1 || ADDR_W > ANGLE_W - 2) begin : g_bad_addr_w
    $error("trig_lut_interp: ADDR_W must lie in 1..ANGLE_W-2");
  end

  logic                    en_s;
  logic                    out_valid_r;
  logic signed [OUT_W-1:0] cosine_r;
  logic signed [OUT_W-1:0] sine_r;
  quadrant_e               quad_s;
  logic [ADDR_W-1:0]       idx_s;
  logic [FBW-1:0]          frac_s;

  assign en_s          = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.cosine    = cosine_r;
  assign bus.sine      = sine_r;

  assign quad_s = quadrant_e'(bus.angle[ANGLE_W-1 -: 2]);
  assign idx_s  = bus.angle[ANGLE_W-3 -: ADDR_W];
  if (FB > 0) begin : g_frac
    assign frac_s = bus.angle[FBW-1:0];
  end else begin : g_no_frac
    assign frac_s = {FBW{1'b0}};
  end

  logic              v1_r;
  quadrant_e         q1_r;
  logic [ADDR_W-1:0] i1_r;
`ifdef TRIG_INTERP_EN
  logic [FBW-1:0]    f1_r;
  logic [FBW-1:0]    f2_r;
`else
  logic              unused_frac_s;
  assign unused_frac_s = ^frac_s;
`endif

  // S1: split the accepted angle into quadrant, table index and fraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      q1_r <= Q0;
      i1_r <= {ADDR_W{1'b0}};
`ifdef TRIG_INTERP_EN
      f1_r <= {FBW{1'b0}};
`endif
    end else if (en_s) begin
      v1_r <= bus.in_valid;
      q1_r <= quad_s;
      i1_r <= idx_s;
`ifdef TRIG_INTERP_EN
      f1_r <= frac_s;
`endif
    end
  end

  // s reads Q[i], c reads Q[2^ADDR_W - i]; the interpolating build also fetches their neighbours.
  logic [ADDR_W:0] addr_s_s;
  logic [ADDR_W:0] addr_c_s;
  logic [TW-1:0]   qs_r;
  logic [TW-1:0]   qc_r;
  assign addr_s_s = {1'b0, i1_r};
  assign addr_c_s = FULL - addr_s_s;

`ifdef TRIG_INTERP_EN
  logic [ADDR_W:0] addr_s1_s;
  logic [ADDR_W:0] addr_c1_s;
  logic [TW-1:0]   qs1_r;
  logic [TW-1:0]   qc1_r;
  assign addr_s1_s = addr_s_s + {{ADDR_W{1'b0}}, 1'b1};
  assign addr_c1_s = addr_c_s - {{ADDR_W{1'b0}}, 1'b1};
`endif

  trig_quarter_rom #(
    .ADDR_W (ADDR_W),
    .FRAC_W (FRAC_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_s),
    .addr_a (addr_s_s),
    .addr_b (addr_c_s),
`ifdef TRIG_INTERP_EN
    .addr_c (addr_s1_s),
    .addr_d (addr_c1_s),
    .data_c (qs1_r),
    .data_d (qc1_r),
`endif
    .data_a (qs_r),
    .data_b (qc_r)
  );

  logic      v2_r;
  quadrant_e q2_r;

  // S2: carry control alongside the registered table read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r <= 1'b0;
      q2_r <= Q0;
`ifdef TRIG_INTERP_EN
      f2_r <= {FBW{1'b0}};
`endif
    end else if (en_s) begin
      v2_r <= v1_r;
      q2_r <= q1_r;
`ifdef TRIG_INTERP_EN
      f2_r <= f1_r;
`endif
    end
  end

  logic [TW-1:0] s_val_s;
  logic [TW-1:0] c_val_s;
`ifdef TRIG_INTERP_EN
  localparam int PW = TW + FBW;
  logic [PW-1:0] s_prod_s;
  logic [PW-1:0] c_prod_s;
  // The table is monotonic over the quarter wave, so both differences are non-negative.
  assign s_prod_s = PW'(qs1_r - qs_r) * PW'(f2_r);
  assign c_prod_s = PW'(qc_r - qc1_r) * PW'(f2_r);
  assign s_val_s  = qs_r + TW'(s_prod_s >> FB);
  assign c_val_s  = qc_r - TW'(c_prod_s >> FB);
`else
  assign s_val_s = qs_r;
  assign c_val_s = qc_r;
`endif

  quad_map_t               map_s;
  logic [TW-1:0]           cos_mag_s;
  logic [TW-1:0]           sin_mag_s;
  logic signed [OUT_W-1:0] cos_ext_s;
  logic signed [OUT_W-1:0] sin_ext_s;
  logic signed [OUT_W-1:0] cos_s;
  logic signed [OUT_W-1:0] sin_s;

  assign map_s     = quad_map(q2_r);
  assign cos_mag_s = map_s.swap ? s_val_s : c_val_s;
  assign sin_mag_s = map_s.swap ? c_val_s : s_val_s;
  assign cos_ext_s = {{(OUT_W - TW){1'b0}}, cos_mag_s};
  assign sin_ext_s = {{(OUT_W - TW){1'b0}}, sin_mag_s};
  assign cos_s     = map_s.neg_cos ? -cos_ext_s : cos_ext_s;
  assign sin_s     = map_s.neg_sin ? -sin_ext_s : sin_ext_s;

  // S3: register the signed results; data only moves when a real sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      cosine_r    <= {OUT_W{1'b0}};
      sine_r      <= {OUT_W{1'b0}};
    end else if (en_s) begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        cosine_r <= cos_s;
        sine_r   <= sin_s;
      end
    end
  end

endmodule
